// File: rtl/pong_pkg.sv
// Shared encodings and defaults for the pong game controller.
package pong_pkg;

  localparam int SCORE_W          = 4;
  localparam int CNT_W            = 9;
  localparam int WIN_SCORE_DEF    = 7;
  localparam int POINT_FRAMES_DEF = 60;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector; history resets to 1 so a level held through reset is not a press.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic hist;

  always_ff @(posedge clk) begin
    if (reset) hist <= 1'b1;
    else       hist <= din;
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/game_fsm.sv
// Pong game sequencer: serve/play/point/over flow, scoring and frame-timed pauses; all outputs registered.
// Optional SERVE_TIMEOUT_EN: auto-serve after SERVE_FRAMES frame ticks in SERVE.
module game_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF,
  parameter int SERVE_FRAMES = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [2:0]         state,
  output logic               ball_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               winner
);

  if (WIN_SCORE < 1 || WIN_SCORE > 15 || POINT_FRAMES < 1 || POINT_FRAMES > 255 ||
      SERVE_FRAMES < 1 || SERVE_FRAMES > 511) begin : g_bad_param
    $error("game_fsm: parameter out of range");
  end

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

  logic press_left, press_right;

  edge_detect u_ed_left  (.clk(clk), .reset(reset), .din(btn_left),  .rise(press_left));
  edge_detect u_ed_right (.clk(clk), .reset(reset), .din(btn_right), .rise(press_right));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
  logic               dir_q, dir_d, win_q, win_d, ball_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
      ball_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      ball_q  <= (state_d == PLAY);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (press_left || press_right) state_d = SERVE;
      SERVE: begin
        if ((!dir_q && press_left) || (dir_q && press_right)) begin
          state_d = PLAY;
        end
`ifdef SERVE_TIMEOUT_EN
        else if (frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) state_d = PLAY;
          else                                   cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          // Simultaneous misses are a dead ball: replay without a point.
          state_d = POINT;
        end else if (miss_left) begin
          sr_d  = (sr_q < WIN) ? sr_q + 1'b1 : sr_q;
          dir_d = 1'b0;
          if (sr_d == WIN) begin
            state_d = OVER;
            win_d   = 1'b1;
          end else begin
            state_d = POINT;
          end
        end else if (miss_right) begin
          sl_d  = (sl_q < WIN) ? sl_q + 1'b1 : sl_q;
          dir_d = 1'b1;
          if (sl_d == WIN) begin
            state_d = OVER;
            win_d   = 1'b0;
          end else begin
            state_d = POINT;
          end
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) state_d = SERVE;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      OVER: begin
        if (press_left || press_right) begin
          state_d = IDLE;
          sl_d    = '0;
          sr_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign state       = state_q;
  assign ball_en     = ball_q;
  assign serve_dir   = dir_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with default parameters; honours SERVE_TIMEOUT_EN when defined.
module tb_game_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       miss_left = 1'b0, miss_right = 1'b0;
  logic [2:0] state;
  logic       ball_en, serve_dir, winner;
  logic [3:0] score_left, score_right;

  int checks = 0;
  int errors = 0;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  game_fsm dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right),
    .miss_left(miss_left), .miss_right(miss_right),
    .state(state), .ball_en(ball_en), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic press(input logic l, input logic r);
    btn_left = l; btn_right = r; step();
  endtask

  task automatic release_btns();
    btn_left = 1'b0; btn_right = 1'b0; step();
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_state", state, S_IDLE);
    chk("rst_ball", ball_en, 0);
    chk("rst_dir", serve_dir, 0);
    chk("rst_sl", score_left, 0);
    chk("rst_sr", score_right, 0);
    chk("rst_win", winner, 0);

    press(1, 0);       chk("idle_to_serve", state, S_SERVE);
    release_btns();
    press(0, 1);       chk("serve_wrong_btn", state, S_SERVE);
    release_btns();
    press(1, 0);       chk("serve_to_play", state, S_PLAY);
    chk("play_ball", ball_en, 1);
    release_btns();

    miss_left = 1'b1; step(); miss_left = 1'b0;
    chk("ml_sr", score_right, 1);
    chk("ml_sl", score_left, 0);
    chk("ml_dir", serve_dir, 0);
    chk("ml_state", state, S_POINT);
    chk("point_ball", ball_en, 0);
    ticks(59);         chk("tick59_point", state, S_POINT);
    ticks(1);          chk("tick60_serve", state, S_SERVE);
    press(1, 0);       chk("serve2_play", state, S_PLAY);
    release_btns();

    for (int i = 1; i <= 6; i++) begin
      miss_right = 1'b1; step(); miss_right = 1'b0;
      chk("mr_sl", score_left, i);
      chk("mr_state", state, S_POINT);
      chk("mr_dir", serve_dir, 1);
      ticks(60);
      chk("mr_serve", state, S_SERVE);
      if (i < 6) begin
        press(0, 1);
        release_btns();
      end
    end

    miss_left = 1'b1; miss_right = 1'b1; step(); miss_left = 1'b0; miss_right = 1'b0;
    miss_left = 1'b1; step(); miss_left = 1'b0;
    chk("serve_miss_state", state, S_SERVE);
    chk("serve_miss_sl", score_left, 6);
    chk("serve_miss_sr", score_right, 1);
    press(1, 0);       chk("serve_dir1_left_ign", state, S_SERVE);
    release_btns();
    press(0, 1);       chk("serve_dir1_right", state, S_PLAY);
    release_btns();

    miss_left = 1'b1; miss_right = 1'b1; step(); miss_left = 1'b0; miss_right = 1'b0;
    chk("both_state", state, S_POINT);
    chk("both_sl", score_left, 6);
    chk("both_sr", score_right, 1);
    chk("both_dir", serve_dir, 1);
    ticks(60);
    press(0, 1);       chk("replay_play", state, S_PLAY);
    release_btns();

    miss_right = 1'b1; step(); miss_right = 1'b0;
    chk("win_state", state, S_OVER);
    chk("win_sl", score_left, 7);
    chk("win_who", winner, 0);
    chk("win_ball", ball_en, 0);
    miss_left = 1'b1; step(); miss_left = 1'b0;
    chk("over_miss_sr", score_right, 1);
    chk("over_hold", state, S_OVER);
    press(0, 1);       chk("over_idle", state, S_IDLE);
    chk("over_clr_sl", score_left, 0);
    chk("over_clr_sr", score_right, 0);
    release_btns();

    press(1, 0);       chk("g2_serve", state, S_SERVE);
    release_btns();
    press(0, 1);       chk("g2_play", state, S_PLAY);
    release_btns();
    reset = 1'b1; miss_left = 1'b1; step(); reset = 1'b0; miss_left = 1'b0;
    chk("rst_prio_state", state, S_IDLE);
    chk("rst_prio_sr", score_right, 0);
    chk("rst_prio_ball", ball_en, 0);

    btn_left = 1'b1; reset = 1'b1; step(); step();
    reset = 1'b0; step(); step(); step();
    chk("held_idle", state, S_IDLE);
    release_btns();    chk("held_rel_idle", state, S_IDLE);
    press(1, 0);       chk("held_repress", state, S_SERVE);
    release_btns();

`ifdef SERVE_TIMEOUT_EN
    ticks(299);        chk("to_299_serve", state, S_SERVE);
    ticks(1);          chk("to_300_play", state, S_PLAY);
    chk("to_ball", ball_en, 1);
`else
    ticks(1000);       chk("no_to_serve", state, S_SERVE);
    chk("no_to_ball", ball_en, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win (range 1..15).
REQ-002 Parameter POINT_FRAMES, default 60, frames of pause after a point (range 1..255).
REQ-003 Parameter SERVE_FRAMES, default 300, frames before auto-serve (only with SERVE_TIMEOUT_EN).
REQ-004 clk  in  1  system clock; only clock in the block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 btn_left, btn_right  in  1 each  debounced button levels.
REQ-008 miss_left, miss_right  in  1 each  one-cycle pulse; ball passed the left or right edge.
REQ-009 state  out  3  current game state code.
REQ-010 ball_en  out  1  ball motion enable for the pixel generator.
REQ-011 serve_dir  out  1  0 = ball launches rightward (left player serves); 1 = leftward.
REQ-012 score_left, score_right  out  4 each  current scores.
REQ-013 winner  out  1  0 = left, 1 = right; valid only in OVER.

Function
REQ-014 The block SHALL register all outputs; a state change is visible the cycle after the qualifying input is sampled.
REQ-015 The block SHALL treat button presses as rising edges only (held buttons do not repeat).
REQ-016 IDLE: ball_en=0; a press on either button SHALL go to SERVE.
REQ-017 SERVE: ball_en=0; only the serving player's press SHALL go to PLAY; the other button is ignored.
REQ-018 PLAY: ball_en=1; miss_left SHALL increment score_right, set serve_dir=0 and go to POINT.
REQ-019 PLAY: miss_right SHALL increment score_left, set serve_dir=1 and go to POINT.
REQ-020 A point that makes a score equal WIN_SCORE SHALL go to OVER instead of POINT, with winner set accordingly.
REQ-021 miss_left and miss_right asserted in the same cycle SHALL award no point and go to POINT with serve_dir unchanged.
REQ-022 Miss pulses outside PLAY SHALL be ignored.
REQ-023 POINT: ball_en=0; counts frame_tick pulses and SHALL go to SERVE on the POINT_FRAMES-th tick.
REQ-024 OVER: ball_en=0; scores held; a press on either button SHALL go to IDLE and clear both scores in the same cycle.
REQ-025 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-026 The frame counter SHALL be 9 bits and SHALL clear on every state transition.

Reset
REQ-027 Reset SHALL set state=IDLE, ball_en=0, serve_dir=0, both scores 0, winner=0, frame counter 0.
REQ-028 Reset SHALL load the edge-detect history registers to 1, so a button held through reset does not register as a press.
REQ-029 Reset asserted mid-game SHALL take priority over every other input in that cycle.

Configuration
REQ-030 With SERVE_TIMEOUT_EN defined, SERVE SHALL go to PLAY automatically after SERVE_FRAMES frame_ticks with no serving press.
REQ-031 Without SERVE_TIMEOUT_EN, SERVE SHALL wait indefinitely, and SERVE_FRAMES SHALL be unused.

Structure
REQ-032 Package pong_pkg SHALL hold: the state encodings (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4), the score width (4), and the WIN_SCORE and POINT_FRAMES defaults.
REQ-033 A sub-module edge_detect (rising-edge detector with reset-to-1 history) SHALL be instantiated once per button.

Verification
REQ-034 Reset, then a btn_left rise -> state=SERVE next cycle; btn_right rise in SERVE (serve_dir=0) -> no change; btn_left rise -> PLAY with ball_en=1.
REQ-035 In PLAY, a miss_left pulse -> score_right=1, serve_dir=0, POINT; after 60 frame_ticks -> SERVE, with no transition on tick 59.
REQ-036 With score_left=6, a miss_right pulse -> score_left=7, OVER, winner=0, ball_en=0; a btn_right rise -> IDLE with scores 0/0.
REQ-037 miss_left and miss_right in the same cycle in PLAY -> scores unchanged, POINT; miss pulses in SERVE -> ignored.
REQ-038 btn_left held high across reset release -> remains IDLE until the button is released and pressed again.
REQ-039 With SERVE_TIMEOUT_EN defined, no press in SERVE -> PLAY on the 300th frame_tick; without the macro -> still SERVE after 1000 ticks.
